// File: rtl/mul_pkg.sv
// Shared encodings for the sequential 8086-style MUL/IMUL unit.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROD = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_LH = 2'd1;
    localparam logic [1:0] STEP_HL = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    localparam int BYTE_STEPS = 1;
    localparam int WORD_STEPS = 4;

    // Two's complement magnitude; 0x8000 stays 0x8000 as an unsigned value.
    function automatic logic [15:0] mag16(input logic [15:0] v, input logic neg);
        return neg ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/multiplier.sv
// 8x8 unsigned combinational multiplier built from shifted partial sums.
module multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    always_comb begin
        p = 16'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p + ({8'd0, a} << i);
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Sequential MUL/IMUL: one 8x8 partial product per cycle, then sign fix and CF/OF.
module mul_sequencer
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_mode,
    input  logic        signed_mode,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        cf_of
);

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] mag_a_q, mag_a_d;
    logic [15:0] mag_b_q, mag_b_d;
    logic        byte_q, byte_d;
    logic        signed_q, signed_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;
    logic        cf_q, cf_d;

    logic        neg_a, neg_b;
    logic [15:0] ext_a, ext_b;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] pp;
    logic [31:0] pp_shift;
    logic        last_step;
    logic        negate;
    logic [31:0] fix_w;
    logic [15:0] fix_b;

    multiplier u_multiplier (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    // Byte operands are sign/zero-extended so one 16-bit magnitude path serves both modes.
    assign neg_a = signed_mode & (byte_mode ? op_a[7] : op_a[15]);
    assign neg_b = signed_mode & (byte_mode ? op_b[7] : op_b[15]);
    assign ext_a = byte_mode ? {{8{neg_a}}, op_a[7:0]} : op_a;
    assign ext_b = byte_mode ? {{8{neg_b}}, op_b[7:0]} : op_b;

    assign mul_a = step_q[1] ? mag_a_q[15:8] : mag_a_q[7:0];
    assign mul_b = step_q[0] ? mag_b_q[15:8] : mag_b_q[7:0];

    always_comb begin
        pp_shift = {16'd0, pp};
        case (step_q)
            STEP_LL:          pp_shift = {16'd0, pp};
            STEP_LH, STEP_HL: pp_shift = {8'd0, pp, 8'd0};
            STEP_HH:          pp_shift = {pp, 16'd0};
            default:          pp_shift = {16'd0, pp};
        endcase
    end

    assign last_step = (step_q == (byte_q ? 2'(BYTE_STEPS - 1) : 2'(WORD_STEPS - 1)));
    assign negate    = signed_q & sign_q;
    assign fix_w     = negate ? (~acc_q + 32'd1) : acc_q;
    assign fix_b     = negate ? (~acc_q[15:0] + 16'd1) : acc_q[15:0];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        step_d   = step_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        byte_d   = byte_q;
        signed_d = signed_q;
        sign_d   = sign_q;
        result_d = result_q;
        cf_d     = cf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    byte_d   = byte_mode;
                    signed_d = signed_mode;
                    mag_a_d  = mag16(ext_a, neg_a);
                    mag_b_d  = mag16(ext_b, neg_b);
                    sign_d   = neg_a ^ neg_b;
                    acc_d    = 32'd0;
                    step_d   = STEP_LL;
                    state_d  = PROD;
                end
            end
            PROD: begin
                acc_d  = acc_q + pp_shift;
                step_d = step_q + 2'd1;
                if (last_step) state_d = FIX;
            end
            FIX: begin
                if (byte_q) begin
                    result_d = {16'd0, fix_b};
                    cf_d     = signed_q ? (fix_b[15:8] != {8{fix_b[7]}}) : (|fix_b[15:8]);
                end else begin
                    result_d = fix_w;
                    cf_d     = signed_q ? (fix_w[31:16] != {16{fix_w[15]}}) : (|fix_w[31:16]);
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= 32'd0;
            step_q   <= 2'd0;
            mag_a_q  <= 16'd0;
            mag_b_q  <= 16'd0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
            cf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            byte_q   <= byte_d;
            signed_q <= signed_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            cf_q     <= cf_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cf_of  = cf_q;

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameters: none; operand width is fixed at 16 bits and byte width at 8 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 byte_mode  input  1  1 = 8x8 (op_a[7:0] * op_b[7:0] -> 16 bits); 0 = 16x16 -> 32 bits.
REQ-006 signed_mode  input  1  1 = IMUL (two's complement); 0 = MUL (unsigned).
REQ-007 op_a  input  16  multiplicand (AL/AX); captured on accepted start.
REQ-008 op_b  input  16  multiplier source; captured on accepted start.
REQ-009 busy  output  1  high from the cycle after accepted start through the DONE cycle.
REQ-010 done  output  1  one-cycle pulse; result and cf_of valid.
REQ-011 result  output  32  product; byte mode uses [15:0], with [31:16] = 0.
REQ-012 cf_of  output  1  8086 CF/OF value for the completed operation.

Function
REQ-013 States: IDLE, PROD, FIX, DONE; after DONE, return unconditionally to IDLE.
REQ-014 IDLE with start=1: capture mode bits and operand magnitudes (absolute value in signed_mode, raw otherwise), record sign = sign(a) XOR sign(b), clear accumulator, clear step counter, go to PROD.
REQ-015 PROD: one 8x8 partial product per cycle through the single shared unsigned multiplier, added to the 32-bit accumulator at the shift for that step.
  - Word step order and shifts: LL<<0, LH<<8, HL<<8, HH<<16.
  - Byte mode: LL only.
REQ-016 After the last step (1 byte / 4 word), go to FIX.
REQ-017 FIX: if signed_mode and sign=1, negate the accumulator (two's complement, 16 bits byte / 32 bits word).
REQ-018 FIX: compute cf_of.
  - Unsigned: 1 iff the upper half is non-zero (byte [15:8], word [31:16]).
  - Signed: 1 iff the upper half is not the sign extension of the lower half.
REQ-019 FIX: go to DONE.
REQ-020 DONE: done=1 and busy=1 for exactly one cycle.
REQ-021 result and cf_of are registered and hold their value until the next accepted start, then change no earlier than FIX.
REQ-022 Latency, counting the start-accept cycle as cycle 0: done is high in cycle 6 (word) or cycle 3 (byte).
REQ-023 start while busy is ignored; no queuing; inputs are not re-sampled.
REQ-024 start held high across DONE is accepted again only in the following IDLE cycle, giving back-to-back ops with one idle cycle.
REQ-025 Magnitude of -32768 / -128 is 0x8000 / 0x80 as an unsigned value; no overflow in the magnitude path.
REQ-026 Operand changes after capture do not affect the result.

Reset
REQ-027 reset=1 at any clock edge (including mid-PROD/FIX) forces IDLE.
  - Clears busy, done, result, cf_of, accumulator and step counter to 0.
  - The aborted operation produces no done pulse.
REQ-028 start asserted in the same cycle as reset is ignored.

Structure
REQ-029 Shared package mul_pkg holds:
  - state encoding (IDLE, PROD, FIX, DONE)
  - step constants (STEP_LL, STEP_LH, STEP_HL, STEP_HH)
  - step counts (BYTE_STEPS=1, WORD_STEPS=4)
REQ-030 Exactly one sub-module instance: the existing 8x8 unsigned combinational multiplier, named multiplier; no second multiplier and no "*" operator.
REQ-031 Accumulator add and negation use ordinary adder logic inside mul_sequencer.

Verification
REQ-032 Word unsigned 0xFFFF*0xFFFF -> result 0xFFFE0001, cf_of=1, done in cycle 6, busy cycles 1-6.
REQ-033 Byte unsigned 0x12*0x10 -> result 0x00000120, cf_of=1, done in cycle 3; op_a[15:8]/op_b[15:8]=0xAA have no effect.
REQ-034 Byte signed cases:
  - 0xFE*0x03 -> result 0x0000FFFA, cf_of=0.
  - 0x80*0x80 -> result 0x00004000, cf_of=1.
REQ-035 Word signed cases:
  - 0x8000*0x8000 -> result 0x40000000, cf_of=1.
  - 0xFFFF*0x0005 -> result 0xFFFFFFFB, cf_of=0.
REQ-036 Overlap: start pulsed again in cycle 2 of a word op with different operands -> ignored; the first result is delivered in cycle 6; a new start in cycle 7 is accepted.
REQ-037 Reset in cycle 3 of a word op -> cycle 4 shows IDLE, busy=0, result=0, and no done pulse.
